// File: rtl/mac_multich_if.sv
// rtl/mac_multich_if.sv - valid/ready beat channel carrying a packed data word
interface mac_multich_if #(
   parameter int W = 1
);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mac_multich.sv
// rtl/mac_multich.sv - time-interleaved multi-channel multiply-accumulate with output FIFO
// Build macro MAC_MULTICH_SAT_EN selects saturating accumulation instead of wrap-around.
module mac_multich #(
   parameter int W_DATA    = 16,
   parameter int W_ACC     = 40,
   parameter int NUM_CH    = 4,
   parameter int W_CH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int OUT_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   mac_multich_if.slave  din,
   mac_multich_if.master dout
);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W = $clog2(OUT_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int W_OUT = W_CH + W_ACC;
   localparam logic [W_CH:0]    NCH_L   = (W_CH + 1)'(NUM_CH);
   localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(OUT_DEPTH);

   logic signed [W_DATA-1:0]   in_mul0;
   logic signed [W_DATA-1:0]   in_mul1;
   logic [W_CH-1:0]            in_ch;
   logic                       in_eot;
   logic signed [2*W_DATA-1:0] in_prod;

   logic                       s1_valid;
   logic                       s1_eot;
   logic [W_CH-1:0]            s1_ch;
   logic signed [W_ACC-1:0]    s1_prod;

   logic signed [W_ACC-1:0]    acc [NUM_CH];
   logic [NUM_CH-1:0]          started;

   logic [W_OUT-1:0]           mem [OUT_DEPTH];
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [CNT_W-1:0]           count;

   logic [IDX_W-1:0]           idx;
   logic                       ch_ok;
   logic                       push;
   logic                       pop;
   logic                       out_valid;
   logic                       take;
   logic signed [W_ACC-1:0]    add_term;
   logic signed [W_ACC-1:0]    sum;

   assign in_mul0 = din.data[W_DATA-1:0];
   assign in_mul1 = din.data[2*W_DATA-1:W_DATA];
   assign in_ch   = din.data[2*W_DATA+W_CH-1:2*W_DATA];
   assign in_eot  = din.data[2*W_DATA+W_CH];
   assign in_prod = in_mul0 * in_mul1;

   // Reserve a FIFO slot for the beat sitting in S1 so nothing in flight can be dropped.
   assign din.ready = rst && ((count + CNT_W'(s1_valid)) < DEPTH_L);
   assign take      = din.valid && din.ready;

   assign idx        = s1_ch[IDX_W-1:0];
   assign ch_ok      = {1'b0, s1_ch} < NCH_L;
   assign push       = s1_valid && ch_ok && s1_eot;
   assign out_valid  = (count != '0);
   assign pop        = out_valid && dout.ready;
   assign dout.valid = out_valid;
   assign dout.data  = mem[rd_ptr];

`ifdef MAC_MULTICH_SAT_EN
   logic signed [W_ACC:0] sum_ext;

   always_comb begin
      add_term = started[idx] ? acc[idx] : '0;
      sum_ext  = {add_term[W_ACC-1], add_term} + {s1_prod[W_ACC-1], s1_prod};
      if (sum_ext[W_ACC] != sum_ext[W_ACC-1])
         sum = sum_ext[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}};
      else
         sum = sum_ext[W_ACC-1:0];
   end
`else
   always_comb begin
      add_term = started[idx] ? acc[idx] : '0;
      sum      = add_term + s1_prod;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_eot   <= 1'b0;
         s1_ch    <= '0;
         s1_prod  <= '0;
         started  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      end else begin
         s1_valid <= take;
         if (take) begin
            s1_prod <= W_ACC'(in_prod);
            s1_ch   <= in_ch;
            s1_eot  <= in_eot;
         end
         // Out-of-range channels pass through S1 and die here untouched.
         if (s1_valid && ch_ok) begin
            acc[idx]     <= sum;
            started[idx] <= !s1_eot;
         end
         if (push) begin
            mem[wr_ptr] <= {s1_ch, sum};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_multich.sv
// tb/tb_mac_multich.sv - self-checking bench for mac_multich against a beat-level reference model
// Expected overflow value follows MAC_MULTICH_SAT_EN when the bench is built with it.
module tb_mac_multich;
   localparam int W_DATA    = 16;
   localparam int W_ACC     = 32;
   localparam int NUM_CH    = 4;
   localparam int W_CH      = 3;
   localparam int OUT_DEPTH = 4;
   localparam int DIN_W     = 1 + W_CH + 2*W_DATA;
   localparam int DOUT_W    = W_CH + W_ACC;
`ifdef MAC_MULTICH_SAT_EN
   localparam longint EXP_OVF = 64'sd2147483647;
`else
   localparam longint EXP_OVF = -64'sd1073741824;
`endif

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   logic [DOUT_W-1:0] obs_d [$];
   int                obs_t [$];
   longint            m_acc [NUM_CH];
   bit                m_started [NUM_CH];
   logic [DOUT_W-1:0] exp_q [$];

   mac_multich_if #(.W(DIN_W))  din ();
   mac_multich_if #(.W(DOUT_W)) dout ();

   mac_multich #(
      .W_DATA(W_DATA), .W_ACC(W_ACC), .NUM_CH(NUM_CH), .W_CH(W_CH), .OUT_DEPTH(OUT_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [DIN_W-1:0] pack(input logic eot, input int ch, input int m1, input int m0);
      logic [W_CH-1:0]   c;
      logic [W_DATA-1:0] a;
      logic [W_DATA-1:0] b;
      c = ch[W_CH-1:0];
      a = m1[W_DATA-1:0];
      b = m0[W_DATA-1:0];
      return {eot, c, a, b};
   endfunction

   function automatic logic [DOUT_W-1:0] mk(input int ch, input longint a);
      logic [W_CH-1:0]  c;
      logic [W_ACC-1:0] v;
      c = ch[W_CH-1:0];
      v = a[W_ACC-1:0];
      return {c, v};
   endfunction

   function automatic longint fit(input longint s);
      longint hi;
      longint lo;
`ifndef MAC_MULTICH_SAT_EN
      longint span;
`endif
      hi = (longint'(1) <<< (W_ACC - 1)) - 1;
      lo = -hi - 1;
`ifdef MAC_MULTICH_SAT_EN
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
`else
      span = longint'(1) <<< W_ACC;
      while (s > hi) s -= span;
      while (s < lo) s += span;
      return s;
`endif
   endfunction

   // Reference: one accepted beat updates the per-channel running sum directly.
   function automatic void model_accept(input logic [DIN_W-1:0] d);
      int     ch;
      longint p;
      longint s;
      logic   eot;
      eot = d[DIN_W-1];
      ch  = int'(d[DIN_W-2 -: W_CH]);
      p   = longint'($signed(d[2*W_DATA-1:W_DATA])) * longint'($signed(d[W_DATA-1:0]));
      if (ch >= NUM_CH) return;
      s = fit((m_started[ch] ? m_acc[ch] : 64'sd0) + p);
      m_acc[ch] = s;
      if (eot) begin
         exp_q.push_back(mk(ch, s));
         m_started[ch] = 1'b0;
      end else begin
         m_started[ch] = 1'b1;
      end
   endfunction

   task automatic cycle(input logic v, input logic [DIN_W-1:0] d, input logic rdy, output logic took);
      @(negedge clk);
      din.valid  = v;
      din.data   = d;
      dout.ready = rdy;
      #1;
      took = din.valid && din.ready;
      if (dout.valid && dout.ready) begin
         obs_d.push_back(dout.data);
         obs_t.push_back(cyc);
      end
      cyc++;
      @(posedge clk);
   endtask

   task automatic offer(input logic [DIN_W-1:0] d, input logic rdy, output int at);
      logic took;
      int   c;
      at = -1;
      for (int k = 0; k < 50; k++) begin
         c = cyc;
         cycle(1'b1, d, rdy, took);
         if (took) begin
            at = c;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      logic took;
      for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b1, took);
   endtask

   task automatic obs_clear;
      obs_d.delete();
      obs_t.delete();
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b0; din.valid = 1'b0; dout.ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0; din.valid = 1'b1; din.data = pack(1'b1, 0, 1, 1); dout.ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b want 0", dout.valid); end
      checks++; if (dout.data !== '0) begin errors++; $display("FAIL reset_dout_data: got %h want 0", dout.data); end
      checks++; if (din.ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b want 0", din.ready); end
      rst = 1'b1; din.valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (din.ready !== 1'b1) begin errors++; $display("FAIL post_reset_din_ready: got %b want 1", din.ready); end
      checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL post_reset_dout_valid: got %b want 0", dout.valid); end
   endtask

   task automatic test_single_channel;
      int a0, a1, a2;
      obs_clear();
      offer(pack(1'b0, 0, 4, 3), 1'b1, a0);
      offer(pack(1'b0, 0, 5, -2), 1'b1, a1);
      offer(pack(1'b1, 0, 7, 7), 1'b1, a2);
      idle(6);
      checks++; if (a2 - a0 != 2 || a1 - a0 != 1) begin errors++; $display("FAIL throughput: accept cycles %0d %0d %0d want consecutive", a0, a1, a2); end
      checks++;
      if (obs_d.size() != 1) begin
         errors++; $display("FAIL single_count: got %0d results want 1", obs_d.size());
      end else begin
         checks++; if (obs_d[0] !== mk(0, 51)) begin errors++; $display("FAIL single_value: got %h want %h", obs_d[0], mk(0, 51)); end
         checks++; if (obs_t[0] != a2 + 2) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", obs_t[0], a2 + 2); end
      end
   endtask

   task automatic test_interleaved;
      int a;
      obs_clear();
      offer(pack(1'b0, 1, 1, 1), 1'b1, a);
      offer(pack(1'b0, 2, 3, -3), 1'b1, a);
      offer(pack(1'b1, 1, 2, 2), 1'b1, a);
      offer(pack(1'b1, 2, 10, 10), 1'b1, a);
      idle(6);
      checks++;
      if (obs_d.size() != 2) begin
         errors++; $display("FAIL interleave_count: got %0d results want 2", obs_d.size());
      end else begin
         checks++; if (obs_d[0] !== mk(1, 5)) begin errors++; $display("FAIL interleave_first: got %h want %h", obs_d[0], mk(1, 5)); end
         checks++; if (obs_d[1] !== mk(2, 91)) begin errors++; $display("FAIL interleave_second: got %h want %h", obs_d[1], mk(2, 91)); end
      end
   endtask

   task automatic test_backpressure;
      logic              took;
      int                sent;
      logic [DIN_W-1:0]  b;
      b = pack(1'b1, 0, 3, 2);
      sent = 0;
      obs_clear();
      for (int k = 0; k < 10; k++) begin
         cycle(sent < 5, b, 1'b0, took);
         if (took) sent++;
      end
      checks++; if (sent != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", sent); end
      checks++; if (took !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", took); end
      cycle(sent < 5, b, 1'b1, took);
      checks++; if (took !== 1'b0) begin errors++; $display("FAIL bp_no_passthrough: got %b want 0", took); end
      if (took) sent++;
      for (int k = 0; k < 20; k++) begin
         cycle(sent < 5, b, 1'b1, took);
         if (took) sent++;
      end
      checks++; if (sent != 5) begin errors++; $display("FAIL bp_total_sent: got %0d want 5", sent); end
      checks++; if (obs_d.size() != 5) begin errors++; $display("FAIL bp_results: got %0d want 5", obs_d.size()); end
      foreach (obs_d[i]) begin
         checks++; if (obs_d[i] !== mk(0, 6)) begin errors++; $display("FAIL bp_value[%0d]: got %h want %h", i, obs_d[i], mk(0, 6)); end
      end
   endtask

   task automatic test_overflow;
      int a;
      obs_clear();
      offer(pack(1'b0, 0, -32768, -32768), 1'b1, a);
      offer(pack(1'b0, 0, -32768, -32768), 1'b1, a);
      offer(pack(1'b1, 0, -32768, -32768), 1'b1, a);
      idle(6);
      checks++;
      if (obs_d.size() != 1) begin
         errors++; $display("FAIL ovf_count: got %0d want 1", obs_d.size());
      end else begin
         checks++; if (obs_d[0] !== mk(0, EXP_OVF)) begin errors++; $display("FAIL ovf_value: got %h want %h", obs_d[0], mk(0, EXP_OVF)); end
      end
   endtask

   task automatic test_reset_mid_packet;
      int a;
      obs_clear();
      offer(pack(1'b1, 1, 2, 2), 1'b0, a);
      offer(pack(1'b0, 3, 5, 5), 1'b0, a);
      offer(pack(1'b0, 3, 5, 5), 1'b0, a);
      @(negedge clk); #1;
      checks++; if (dout.valid !== 1'b1) begin errors++; $display("FAIL mid_queued_valid: got %b want 1", dout.valid); end
      rst = 1'b0; din.valid = 1'b1; din.data = pack(1'b1, 3, 1, 1);
      #1;
      checks++; if (din.ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", din.ready); end
      @(negedge clk); #1;
      checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", dout.valid); end
      rst = 1'b1; din.valid = 1'b0; dout.ready = 1'b1;
      obs_clear();
      offer(pack(1'b1, 3, 1, 1), 1'b1, a);
      idle(6);
      checks++;
      if (obs_d.size() != 1) begin
         errors++; $display("FAIL mid_count: got %0d want 1", obs_d.size());
      end else begin
         checks++; if (obs_d[0] !== mk(3, 1)) begin errors++; $display("FAIL mid_value: got %h want %h", obs_d[0], mk(3, 1)); end
      end
   endtask

   task automatic test_invalid_channel;
      int a;
      obs_clear();
      offer(pack(1'b1, 5, 9, 9), 1'b1, a);
      offer(pack(1'b1, 0, 2, 1), 1'b1, a);
      idle(6);
      checks++;
      if (obs_d.size() != 1) begin
         errors++; $display("FAIL invalid_count: got %0d want 1", obs_d.size());
      end else begin
         checks++; if (obs_d[0] !== mk(0, 2)) begin errors++; $display("FAIL invalid_value: got %h want %h", obs_d[0], mk(0, 2)); end
      end
   endtask

   task automatic test_random;
      logic             took;
      logic             v;
      logic             rdy;
      logic [DIN_W-1:0] d;
      int               m0;
      int               m1;
      do_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_acc[c] = 0;
         m_started[c] = 1'b0;
      end
      exp_q.delete();
      obs_clear();
      v = 1'b0;
      d = '0;
      for (int k = 0; k < 600; k++) begin
         if (!v && $urandom_range(0, 3) != 0) begin
            m0 = ($urandom_range(0, 3) == 0) ? -32768 : int'($urandom_range(0, 65535));
            m1 = ($urandom_range(0, 3) == 0) ? -32768 : int'($urandom_range(0, 65535));
            d  = pack($urandom_range(0, 3) == 0, int'($urandom_range(0, 5)), m1, m0);
            v  = 1'b1;
         end
         rdy = ($urandom_range(0, 3) != 0);
         cycle(v, d, rdy, took);
         if (took) begin
            model_accept(d);
            v = 1'b0;
         end
      end
      idle(20);
      checks++; if (obs_d.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d results want %0d", obs_d.size(), exp_q.size()); end
      for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL rand_result[%0d]: got %h want %h", i, obs_d[i], exp_q[i]); end
      end
   endtask

   initial begin
      din.valid  = 1'b0;
      din.data   = '0;
      dout.ready = 1'b0;
      rst        = 1'b0;
      test_reset();
      test_single_channel();
      test_interleaved();
      test_backpressure();
      test_overflow();
      test_reset_mid_packet();
      test_invalid_channel();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mac_multich.md
Name: mac_multich

Overview:
Parametrised successor to the single-channel multiply-accumulate gear. It serves NUM_CH time-interleaved channels from one dti stream, with one accumulator per channel and a configurable accumulator width. It has a registered multiplier stage and an output FIFO, so downstream backpressure does not stall accumulation until the FIFO fills. It sits between the tagged coefficient/sample mux and the per-channel post-processing in the filter datapath.

Parameters:
- W_DATA, 16, signed operand width (mul0, mul1).
- W_ACC, 40, signed accumulator and result width; must be >= 2*W_DATA.
- NUM_CH, 4, number of interleaved channels; >= 1.
- W_CH, $clog2(NUM_CH) (min 1), channel tag width.
- OUT_DEPTH, 4, output FIFO depth; power of 2, >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- din.data  input  1+W_CH+2*W_DATA  packed {eot, ch, mul1, mul0}, MSB first.
- din.valid  input  1  input beat valid.
- din.ready  output  1  input beat accepted.
- dout.data  output  W_CH+W_ACC  packed {ch, acc}.
- dout.valid  output  1  result available.
- dout.ready  input  1  downstream accepts result.

Behaviour:
- Handshakes follow dti: a transfer occurs when valid && ready. Data is held stable while valid is high and ready is low.
- Reset (rst==0 at posedge): all accumulators = 0; all per-channel cleared flags = 0; S1 valid = 0; FIFO empty; dout.valid = 0; dout.data = 0. din.ready is forced 0 while rst==0.
- din.ready = (fifo_count + s1_valid) < OUT_DEPTH. This guarantees every in-flight beat has a FIFO slot. A same-cycle FIFO pop does not raise ready (no pass-through).
- Stage S1, on the input handshake edge: register the signed product mul0*mul1 (2*W_DATA bits, sign-extended to W_ACC), plus ch and eot; set s1_valid. If no handshake, s1_valid <= 0.
- Stage S2, on the next edge when s1_valid:
  - add_term = started[ch] ? acc[ch] : 0.
  - sum = add_term + prod, modulo 2^W_ACC (two's complement wrap).
  - acc[ch] <= sum.
  - If eot: push {ch, sum} into the FIFO and set started[ch] <= 0. Otherwise set started[ch] <= 1.
- Read-modify-write happens in a single cycle, so back-to-back beats on the same channel need no forwarding.
- Latency: an eot beat accepted at cycle t produces dout.valid at t+2 when the FIFO is empty. Throughput is 1 beat per cycle.
- Results leave in eot-acceptance order across channels.
- Single-beat packet (first beat has eot=1): result = product.
- ch >= NUM_CH: the beat is accepted, flows through S1, and is discarded in S2. No accumulator, flag or FIFO change.
- FIFO: simultaneous push and pop keeps the count unchanged. dout.valid = !empty. dout.data = head entry.
- Reset mid-packet discards all partial sums and queued results.

Optional Feature:
MAC_MULTICH_SAT_EN
- Defined: S2 uses saturating addition. On positive overflow sum = 2^(W_ACC-1)-1; on negative overflow sum = -2^(W_ACC-1). Later beats accumulate from the clamped value.
- Undefined: wrap-around as above, with no saturation logic instantiated.
- Port widths are identical in both builds.

Test Plan:
- NUM_CH=4, W_ACC=40, ch0 beats (3,4),(-2,5),(7,7,eot) -> one dout {ch=0, acc=51} exactly 2 cycles after the eot handshake.
- Interleaved: ch1 (1,1); ch2 (-3,3); ch1 (2,2,eot); ch2 (10,10,eot) -> dout {1,5} then {2,91}, with no cross-channel contamination.
- Backpressure: dout.ready=0, OUT_DEPTH=4, five single-beat ch0 (2,3,eot) beats offered -> din.ready drops after 4 accepted. Raise dout.ready -> five results of 6 delivered in order, with no loss or duplication.
- Overflow: W_ACC=32, ch0 (-32768,-32768) x3 with eot on the last beat:
  - without the macro -> acc = -1073741824;
  - with MAC_MULTICH_SAT_EN -> acc = 2147483647.
- Reset mid-packet: ch3 (5,5),(5,5) without eot, rst low for 1 cycle, then ch3 (1,1,eot) -> dout {3,1}. dout.valid=0 and din.ready=0 during reset.
- Invalid channel: NUM_CH=4 but W_CH=3 forced, ch=5 (9,9,eot), then ch0 (1,2,eot) -> only {0,2} emitted.
